mem_access_stage: RTL
=====================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-low reset, sampled only on the clk rising edge.
REQ-003 SHALL have inputs exmem_branch, exmem_memread, exmem_memwrite, exmem_memtoreg, exmem_regwrite, exmem_jal, exmem_zero, each 1 bit: EX/MEM control and zero flag.
REQ-004 SHALL have inputs exmem_rd (5 bits) and exmem_adder2out, exmem_result, exmem_writedata, exmem_adder_out1 (64 bits each): destination register, branch target, ALU result/address, store data, PC+4.
REQ-005 SHALL have outputs dmem_req, dmem_we (1 bit each) and dmem_addr, dmem_wdata (64 bits each): data-memory request port.
REQ-006 SHALL have inputs dmem_ack (1 bit) and dmem_rdata (64 bits): memory completion and read data.
REQ-007 SHALL have outputs mem_stall, pc_src, mem_err (1 bit each) and branch_target (64 bits).
REQ-008 SHALL have outputs memwb_regwrite, memwb_memtoreg, memwb_jal (1 bit each), memwb_rd (5 bits), memwb_readdata, memwb_result, memwb_adder_out1 (64 bits each): the MEM/WB pipeline register.

Function
REQ-009 SHALL implement a 3-state FSM IDLE, BUSY, DONE, plus a 4-bit wait counter.
REQ-010 access = exmem_memread | exmem_memwrite; both high SHALL be treated as a write.
REQ-011 In IDLE with access=1, SHALL assert mem_stall combinationally and move to BUSY at the next edge, with wait counter cleared.
REQ-012 In BUSY, dmem_req SHALL be 1, dmem_we = exmem_memwrite, dmem_addr = exmem_result, dmem_wdata = exmem_writedata, and mem_stall SHALL be 1.
REQ-013 Outside BUSY, dmem_req and dmem_we SHALL be 0; dmem_ack SHALL be ignored in IDLE and DONE.
REQ-014 In BUSY with dmem_ack=1, SHALL capture dmem_rdata into an internal buffer (reads only) and move to DONE.
REQ-015 In BUSY with dmem_ack=0, SHALL increment the wait counter; if the counter = 15 and ack = 0, SHALL move to DONE, load the buffer with 0, and set mem_err.
REQ-016 mem_err SHALL be sticky, cleared only by reset.
REQ-017 In DONE, mem_stall SHALL be 0, the MEM/WB register SHALL load the current EX/MEM fields plus the buffer as memwb_readdata, and the FSM SHALL return to IDLE.
REQ-018 Minimum load/store latency: 2 stall cycles (ack in first BUSY cycle); maximum: 17 stall cycles (timeout).
REQ-019 In IDLE with access=0, MEM/WB SHALL load the EX/MEM fields every cycle, with memwb_readdata = 0.
REQ-020 In any cycle with mem_stall=1, MEM/WB SHALL load a bubble: regwrite, memtoreg and jal set to 0; other fields hold.
REQ-021 pc_src SHALL = ((exmem_branch & exmem_zero) | exmem_jal) when state = IDLE and access = 0, else 0; branch_target SHALL = exmem_adder2out.
REQ-022 The upstream EX/MEM register SHALL treat mem_stall=1 as hold; this block relies on EX/MEM fields being stable while stalled.

Reset
REQ-023 With reset=0 at an edge, SHALL set state=IDLE, wait counter=0, buffer=0, mem_err=0, and all memwb_* outputs to 0.
REQ-024 Reset SHALL override any in-flight access: dmem_req SHALL be 0 in the cycle after the reset edge, and a late dmem_ack SHALL be ignored.
REQ-025 Combinational outputs (mem_stall, pc_src) SHALL follow the reset state; no access SHALL start in a cycle where reset=0.

Verification
REQ-026 Load, ack on first BUSY cycle: memread=1, result=0x100, rdata=0xDEADBEEF -> stall 2 cycles, then memwb_readdata=0xDEADBEEF, memwb_memtoreg=1.
REQ-027 Store, ack after 3 cycles: memwrite=1, writedata=0x55 -> dmem_we=1, dmem_wdata=0x55 for 3 BUSY cycles, stall 4 cycles, then memwb_regwrite=0.
REQ-028 Timeout: load, never ack -> stall 17 cycles, then memwb_readdata=0, mem_err=1 and held until reset.
REQ-029 Branch: branch=1, zero=1, adder2out=0x40, no access -> pc_src=1, branch_target=0x40 same cycle; with zero=0 -> pc_src=0; jal=1 -> pc_src=1.
REQ-030 Reset mid-BUSY: reset=0 on the 2nd BUSY cycle -> next cycle state IDLE, dmem_req=0, memwb_* all 0, a subsequent ack has no effect.
REQ-031 Back-to-back loads: two consecutive loads each with immediate ack -> each yields 2 stall cycles and the correct, in-order memwb_readdata.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// ---------------------------------------------------------------------------
// mem_access_stage_if : data-memory request/response bus of the MEM stage
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage : pipeline MEM stage with stalling data-memory access,
//                    timeout error flag and MEM/WB pipeline register
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_access_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        exmem_branch,
    input  logic        exmem_memread,
    input  logic        exmem_memwrite,
    input  logic        exmem_memtoreg,
    input  logic        exmem_regwrite,
    input  logic        exmem_jal,
    input  logic        exmem_zero,
    input  logic [4:0]  exmem_rd,
    input  logic [63:0] exmem_adder2out,
    input  logic [63:0] exmem_result,
    input  logic [63:0] exmem_writedata,
    input  logic [63:0] exmem_adder_out1,
    mem_access_stage_if.master dmem,
    output logic        mem_stall,
    output logic        pc_src,
    output logic        mem_err,
    output logic [63:0] branch_target,
    output logic        memwb_regwrite,
    output logic        memwb_memtoreg,
    output logic        memwb_jal,
    output logic [4:0]  memwb_rd,
    output logic [63:0] memwb_readdata,
    output logic [63:0] memwb_result,
    output logic [63:0] memwb_adder_out1
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [3:0] WAIT_MAX = 4'd15;

    logic [1:0]  state_q,    state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [63:0] rbuf_q,     rbuf_d;
    logic        mem_err_q,  mem_err_d;
    logic        access;

    logic        memwb_regwrite_q, memwb_memtoreg_q, memwb_jal_q;
    logic [4:0]  memwb_rd_q;
    logic [63:0] memwb_readdata_q, memwb_result_q, memwb_adder_out1_q;

    assign access = exmem_memread | exmem_memwrite;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 4'd0;
            rbuf_q     <= 64'd0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rbuf_q     <= rbuf_d;
            mem_err_q  <= mem_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        rbuf_d     = rbuf_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    state_d    = S_BUSY;
                    wait_cnt_d = 4'd0;
                end
            end
            S_BUSY: begin
                if (dmem.dmem_ack) begin
                    state_d = S_DONE;
                    if (!exmem_memwrite) rbuf_d = dmem.dmem_rdata;
                end else if (wait_cnt_q == WAIT_MAX) begin
                    // Memory never answered: finish with zero data and flag it
                    state_d   = S_DONE;
                    rbuf_d    = 64'd0;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_stall       = 1'b0;
        pc_src          = 1'b0;
        dmem.dmem_req   = 1'b0;
        dmem.dmem_we    = 1'b0;
        dmem.dmem_addr  = 64'd0;
        dmem.dmem_wdata = 64'd0;
        case (state_q)
            S_IDLE: begin
                mem_stall = access;
                pc_src    = ~access & ((exmem_branch & exmem_zero) | exmem_jal);
            end
            S_BUSY: begin
                mem_stall       = 1'b1;
                dmem.dmem_req   = 1'b1;
                dmem.dmem_we    = exmem_memwrite;
                dmem.dmem_addr  = exmem_result;
                dmem.dmem_wdata = exmem_writedata;
            end
            default: ;
        endcase
    end

    // Stalled cycles insert a bubble; all other cycles advance EX/MEM into MEM/WB
    always_ff @(posedge clk) begin
        if (!reset) begin
            memwb_regwrite_q   <= 1'b0;
            memwb_memtoreg_q   <= 1'b0;
            memwb_jal_q        <= 1'b0;
            memwb_rd_q         <= 5'd0;
            memwb_readdata_q   <= 64'd0;
            memwb_result_q     <= 64'd0;
            memwb_adder_out1_q <= 64'd0;
        end else if (mem_stall) begin
            memwb_regwrite_q   <= 1'b0;
            memwb_memtoreg_q   <= 1'b0;
            memwb_jal_q        <= 1'b0;
        end else begin
            memwb_regwrite_q   <= exmem_regwrite;
            memwb_memtoreg_q   <= exmem_memtoreg;
            memwb_jal_q        <= exmem_jal;
            memwb_rd_q         <= exmem_rd;
            memwb_readdata_q   <= (state_q == S_DONE) ? rbuf_q : 64'd0;
            memwb_result_q     <= exmem_result;
            memwb_adder_out1_q <= exmem_adder_out1;
        end
    end

    assign mem_err          = mem_err_q;
    assign branch_target    = exmem_adder2out;
    assign memwb_regwrite   = memwb_regwrite_q;
    assign memwb_memtoreg   = memwb_memtoreg_q;
    assign memwb_jal        = memwb_jal_q;
    assign memwb_rd         = memwb_rd_q;
    assign memwb_readdata   = memwb_readdata_q;
    assign memwb_result     = memwb_result_q;
    assign memwb_adder_out1 = memwb_adder_out1_q;

endmodule

`default_nettype wire
